// File: rtl/apb_uart_rx.sv
// APB-attached UART receiver: 8N1 deserializer feeding a byte FIFO, with a
// STATUS register carrying FIFO count and sticky overrun / framing-error flags.
module apb_uart_rx #(
    parameter int BUS_WIDTH    = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           S_PADDR,
    input  logic                 S_PWRITE,
    input  logic                 S_PSELx,
    input  logic                 S_PENABLE,
    input  logic [BUS_WIDTH-1:0] S_PWDATA,
    output logic [BUS_WIDTH-1:0] S_PRDATA,
    output logic                 S_PREADY,
    input  logic                 rx_wire,
    output logic                 rx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic           r_rx_meta;
    logic           r_rx_sync;
    logic           r_rx_prev;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_nxt;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_nxt;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_nxt;
    logic           w_push_req;
    logic           w_frame_set;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_frame_err;
    logic           r_overrun;
    logic           r_rd_done;

    logic           w_apb_sel;
    logic           w_stat_wr;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_ovr_set;
    logic [BUS_WIDTH-1:0] w_prdata;
    logic           w_pready;
    logic           w_unused;

    assign w_apb_sel = S_PSELx & S_PENABLE;
    assign w_stat_wr = w_apb_sel & S_PWRITE & (S_PADDR == 2'd1);
    assign w_empty   = (r_count == CW'(0));
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    // r_rd_done keeps a read that is held past its completion from popping again
    assign w_pop     = w_apb_sel & ~S_PWRITE & (S_PADDR == 2'd0) & ~w_empty & ~r_rd_done;
    assign w_push    = w_push_req & (~w_full | w_pop);
    assign w_ovr_set = w_push_req & w_full & ~w_pop;
    assign w_unused  = ^S_PWDATA[BUS_WIDTH-1:2];

    // Synchronizer plus one extra sample for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_wire;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Receiver next-state logic; bits are sampled mid-bit once START is verified.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push_req    = 1'b0;
        w_frame_set   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt     = 16'd0;
                w_bit_idx_nxt = 3'd0;
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_nxt = 16'd0;
                    if (!r_rx_sync) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt   = 16'd0;
                    w_shift_nxt = {r_rx_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_state_nxt   = DATA;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            STOP: begin
                if (r_cnt == BIT_M1) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = IDLE;
                    if (r_rx_sync) begin
                        w_push_req = 1'b1;
                    end else begin
                        w_frame_set = 1'b1;
                    end
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy, sticky flags and per-transfer pop guard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rd_done   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_frame_err <= w_frame_set | (r_frame_err & ~(w_stat_wr & S_PWDATA[0]));
            r_overrun   <= w_ovr_set   | (r_overrun   & ~(w_stat_wr & S_PWDATA[1]));
            if (!w_apb_sel) begin
                r_rd_done <= 1'b0;
            end else if (w_pop) begin
                r_rd_done <= 1'b1;
            end
        end
    end

    // APB read mux and ready; DATA reads stall while the FIFO is empty.
    always_comb begin
        w_pready = 1'b0;
        w_prdata = '0;
        if (w_apb_sel) begin
            case (S_PADDR)
                2'd0: begin
                    if (S_PWRITE) begin
                        w_pready = 1'b1;
                    end else begin
                        w_pready = ~w_empty;
                        if (!w_empty) begin
                            w_prdata[7:0] = r_mem[r_rd_ptr];
                        end else begin
                            w_prdata = '0;
                        end
                    end
                end
                2'd1: begin
                    w_pready = 1'b1;
                    if (!S_PWRITE) begin
                        w_prdata[8:2] = 7'(r_count);
                        w_prdata[1]   = r_overrun;
                        w_prdata[0]   = r_frame_err;
                    end else begin
                        w_prdata = '0;
                    end
                end
                default: begin
                    w_pready = 1'b1;
                end
            endcase
        end else begin
            w_pready = 1'b0;
            w_prdata = '0;
        end
    end

    assign S_PREADY = w_pready;
    assign S_PRDATA = w_prdata;
    assign rx_irq   = ~w_empty | r_frame_err | r_overrun;

endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed, table-driven bench for apb_uart_rx with CLKS_PER_BIT=16, FIFO_DEPTH=8.
`timescale 1ns/1ps
module tb_apb_uart_rx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;
    logic        rx;
    logic        irq;

    int cyc = 0;
    int t_fall = 0;
    int ready_cyc = 0;
    int n_checks = 0;
    int n_err = 0;

    typedef enum int {OP_SEND, OP_RD, OP_WR, OP_GLITCH} op_e;
    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic [15:0] arg;
        logic        stop;
        logic [15:0] exp_data;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[$];

    apb_uart_rx #(.BUS_WIDTH(16), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite),
        .S_PSELx(psel), .S_PENABLE(penable), .S_PWDATA(pwdata),
        .S_PRDATA(prdata), .S_PREADY(pready), .rx_wire(rx), .rx_irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        t_fall = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic apb_read(input logic [1:0] addr, output logic [15:0] data);
        int n;
        @(negedge clk);
        paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        n = 0;
        while (!pready && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!pready) begin
            check("read_timeout", {31'd0, pready}, 32'd1);
        end
        data = prdata;
        ready_cyc = cyc;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] addr, input logic [15:0] data);
        @(negedge clk);
        paddr = addr; pwrite = 1'b1; pwdata = data; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    function automatic void add(op_e op, logic [1:0] addr, logic [15:0] arg, logic stop,
                                logic [15:0] exp_data, logic exp_irq);
        vec_t v;
        v.op = op; v.addr = addr; v.arg = arg; v.stop = stop;
        v.exp_data = exp_data; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        reset = 1'b1; rx = 1'b1; paddr = 2'd0; pwrite = 1'b0;
        psel = 1'b0; penable = 1'b0; pwdata = 16'd0;

        // status value = count<<2 | overrun<<1 | frame_err
        add(OP_RD,     2'd1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        add(OP_SEND,   2'd0, 16'h005A, 1'b1, 16'h0004, 1'b1);
        add(OP_RD,     2'd0, 16'h0000, 1'b1, 16'h005A, 1'b0);
        add(OP_RD,     2'd1, 16'h0000, 1'b1, 16'h0000, 1'b0);
        add(OP_SEND,   2'd0, 16'h00FF, 1'b0, 16'h0001, 1'b1);
        add(OP_WR,     2'd1, 16'h0001, 1'b1, 16'h0000, 1'b0);
        add(OP_GLITCH, 2'd0, 16'h0004, 1'b1, 16'h0000, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            add(OP_SEND, 2'd0, 16'(i * 17), 1'b1,
                (i <= 8) ? 16'(i * 4) : 16'h0022, 1'b1);
        end
        for (int i = 1; i <= 8; i++) begin
            add(OP_RD, 2'd0, 16'h0000, 1'b1, 16'(i * 17), 1'b1);
        end
        add(OP_RD,     2'd1, 16'h0000, 1'b1, 16'h0002, 1'b1);
        add(OP_WR,     2'd1, 16'h0002, 1'b1, 16'h0000, 1'b0);
        add(OP_WR,     2'd0, 16'h00AB, 1'b1, 16'h0000, 1'b0);
        add(OP_RD,     2'd2, 16'h0000, 1'b1, 16'h0000, 1'b0);
        add(OP_RD,     2'd3, 16'h0000, 1'b1, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_pready", {31'd0, pready}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[k]) begin
            case (vecs[k].op)
                OP_SEND: begin
                    send_byte(vecs[k].arg[7:0], vecs[k].stop);
                    apb_read(2'd1, d);
                end
                OP_WR: begin
                    apb_write(vecs[k].addr, vecs[k].arg);
                    apb_read(2'd1, d);
                end
                OP_GLITCH: begin
                    @(negedge clk);
                    rx = 1'b0;
                    repeat (int'(vecs[k].arg)) @(negedge clk);
                    rx = 1'b1;
                    repeat (3 * CPB) @(negedge clk);
                    apb_read(2'd1, d);
                end
                default: begin
                    apb_read(vecs[k].addr, d);
                end
            endcase
            #1;
            check($sformatf("vec%0d_data", k), {16'd0, d}, {16'd0, vecs[k].exp_data});
            check($sformatf("vec%0d_irq", k), {31'd0, irq}, {31'd0, vecs[k].exp_irq});
        end

        // Stalled DATA read completes the cycle after the stop-bit sample.
        fork
            send_byte(8'hC3, 1'b1);
            begin
                repeat (3) @(negedge clk);
                apb_read(2'd0, d);
            end
        join
        check("stall_data", {16'd0, d}, 32'h0000_00C3);
        check("stall_latency", ready_cyc - t_fall, 32'd155);
        apb_read(2'd1, d);
        check("stall_status", {16'd0, d}, 32'h0000_0000);

        // Reset in the middle of data bit 4 abandons the frame.
        send_byte(8'h42, 1'b1);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        b = 8'h3C;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midframe_reset_irq", {31'd0, irq}, 32'd0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        apb_read(2'd1, d);
        check("post_reset_status", {16'd0, d}, 32'h0000_0000);
        send_byte(8'h81, 1'b1);
        apb_read(2'd0, d);
        check("post_reset_data", {16'd0, d}, 32'h0000_0081);
        apb_read(2'd1, d);
        check("post_reset_empty", {16'd0, d}, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
